// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared constants and helpers for the SHA-256 compression
//               core: word/round sizing, FSM state encoding, SHA-256 and
//               SHA-224 initial hash values, the K[0..63] round-constant
//               table and the S0/S1/Ch/Maj round functions.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    localparam int c_word_w  = 32;
    localparam int c_rounds  = 64;
    localparam int c_state_w = 3;

    // Compression FSM encoding
    localparam logic [c_state_w-1:0] c_st_idle  = 3'd0;
    localparam logic [c_state_w-1:0] c_st_init  = 3'd1;
    localparam logic [c_state_w-1:0] c_st_round = 3'd2;
    localparam logic [c_state_w-1:0] c_st_final = 3'd3;
    localparam logic [c_state_w-1:0] c_st_done  = 3'd4;

    // Initial hash values, H0 in the most significant word
    localparam logic [255:0] c_iv_256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] c_iv_224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    // Round constants, K[0] in the most significant word
    localparam logic [c_rounds*c_word_w-1:0] c_k_table = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    // S0(a) = ror2 ^ ror13 ^ ror22
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    // S1(e) = ror6 ^ ror11 ^ ror25
    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_k_rom.sv
`default_nettype none
// ============================================================================
// Module      : sha256_k_rom
// Description : Combinational SHA-256 round-constant lookup, K[i_addr].
// Ports       : i_addr [5:0]  - round index t
//               o_k    [31:0] - K[t]
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  i_addr,
    output logic [31:0] o_k
);

    // K[0] sits in the top word, so word t starts at bit (63 - t) * 32,
    // which is {~t, 5'b0} for a 6-bit index.
    logic [10:0] w_base;

    assign w_base = {~i_addr, 5'b00000};
    assign o_k    = c_k_table[w_base +: 32];

endmodule : sha256_k_rom
`default_nettype wire

// File: rtl/sha256_round_core.sv
`default_nettype none
// ============================================================================
// Module      : sha256_round_core
// Description : SHA-256 compression stage. Streams W[0..63] from the message
//               schedule generator, runs 64 rounds on a..h, folds the result
//               into H0..H7 and presents the digest with a one-cycle done.
// Ports       : clock       - rising-edge clock
//               reset       - asynchronous active-low reset
//               start       - one-cycle pulse, compress one block
//               first_block - with start: 1 = load IV, 0 = chain from H
//               mode_224    - with start: select SHA-224 IV / digest
//                             (only when SHA256_CORE_SHA224_EN is defined)
//               w_reg_rdy   - generator can accept a W read
//               w_reg_data  - W[t], W_LAT cycles after its read
//               w_reg_read  - W read strobe
//               w_reg_addr  - index t of the W read
//               busy        - compressing (INIT through FINAL)
//               done        - one-cycle pulse, hash_out updated
//               hash_out    - H0..H7, H0 in [255:224]
// Config      : `define SHA256_CORE_SHA224_EN adds the SHA-224 mode.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_round_core
    import sha256_pkg::*;
#(
    parameter int W_LAT  = 2,
    parameter int ROUNDS = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         first_block,
`ifdef SHA256_CORE_SHA224_EN
    input  logic         mode_224,
`endif
    input  logic         w_reg_rdy,
    input  logic [31:0]  w_reg_data,
    output logic         w_reg_read,
    output logic [5:0]   w_reg_addr,
    output logic         busy,
    output logic         done,
    output logic [255:0] hash_out
);

    localparam int                 c_cnt_w      = $clog2(ROUNDS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_rounds = c_cnt_w'(ROUNDS);
    localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(ROUNDS - 1);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;

    logic                 r_first;
    logic [7:0][31:0]     r_hash;      // [7] = H0 ... [0] = H7
    logic [7:0][31:0]     r_var;       // [7] = a  ... [0] = h
    logic [c_cnt_w-1:0]   r_issue_cnt;
    logic [c_cnt_w-1:0]   r_round_cnt;
    logic [W_LAT-1:0]     r_vld;
    logic [255:0]         r_hash_out;

    logic                 w_issue;
    logic                 w_exec;
    logic                 w_last;
    logic [31:0]          w_k;
    logic [31:0]          w_t1;
    logic [31:0]          w_t2;
    logic [7:0][31:0]     w_var_nxt;
    logic [7:0][31:0]     w_sum;
    logic [255:0]         w_iv;
    logic [255:0]         w_digest;

`ifdef SHA256_CORE_SHA224_EN
    logic                 r_mode_224;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mode_224 <= 1'b0;
        end else if (r_state == c_st_idle && start) begin
            r_mode_224 <= mode_224;
        end
    end

    assign w_iv     = r_mode_224 ? c_iv_224 : c_iv_256;
    // The 224-bit digest is H0..H6; the unused low word reads as zero.
    assign w_digest = r_mode_224 ? {w_sum[7:1], 32'h0} : w_sum;
`else
    assign w_iv     = c_iv_256;
    assign w_digest = w_sum;
`endif

    // ------------------------------------------------------------------
    // Issue / execute qualifiers
    // ------------------------------------------------------------------
    assign w_issue = (r_state == c_st_round) && (r_issue_cnt < c_cnt_rounds) && w_reg_rdy;
    // The tail of the valid pipe marks the cycle w_reg_data carries W[round_cnt].
    assign w_exec  = (r_state == c_st_round) && r_vld[W_LAT-1];
    assign w_last  = w_exec && (r_round_cnt == c_cnt_last);

    assign w_reg_read = w_issue;
    assign w_reg_addr = w_issue ? r_issue_cnt[5:0] : 6'd0;
    assign busy       = (r_state == c_st_init) || (r_state == c_st_round) ||
                        (r_state == c_st_final);
    assign done       = (r_state == c_st_done);
    assign hash_out   = r_hash_out;

    // ------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------
    sha256_k_rom u_k_rom (
        .i_addr (r_round_cnt[5:0]),
        .o_k    (w_k)
    );

    assign w_t1 = r_var[0] + big_sigma1(r_var[3]) + ch(r_var[3], r_var[2], r_var[1]) +
                  w_k + w_reg_data;
    assign w_t2 = big_sigma0(r_var[7]) + maj(r_var[7], r_var[6], r_var[5]);

    // a <= T1+T2, b <= a, c <= b, d <= c, e <= d+T1, f <= e, g <= f, h <= g
    assign w_var_nxt = {w_t1 + w_t2, r_var[7], r_var[6], r_var[5],
                        r_var[4] + w_t1, r_var[3], r_var[2], r_var[1]};

    generate
        for (genvar i = 0; i < 8; i++) begin : g_fold
            assign w_sum[i] = r_hash[i] + r_var[i];
        end
    endgenerate

    // Outstanding-read tracker: one bit per read in flight.
    generate
        if (W_LAT == 1) begin : g_vld_single
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) r_vld <= '0;
                else        r_vld <= w_issue;
            end
        end else begin : g_vld_multi
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) r_vld <= '0;
                else        r_vld <= {r_vld[W_LAT-2:0], w_issue};
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            c_st_idle:  if (start) w_state_nxt = c_st_init;
            c_st_init:  w_state_nxt = c_st_round;
            c_st_round: if (w_last) w_state_nxt = c_st_final;
            c_st_final: w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Working state, chaining hash and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_first     <= 1'b0;
            r_hash      <= '0;
            r_var       <= '0;
            r_issue_cnt <= '0;
            r_round_cnt <= '0;
            r_hash_out  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_first     <= first_block;
                        r_issue_cnt <= '0;
                        r_round_cnt <= '0;
                    end
                end
                c_st_init: begin
                    if (r_first) begin
                        r_hash <= w_iv;
                        r_var  <= w_iv;
                    end else begin
                        r_var  <= r_hash;
                    end
                end
                c_st_round: begin
                    if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
                    if (w_exec) begin
                        r_var       <= w_var_nxt;
                        r_round_cnt <= r_round_cnt + 1'b1;
                    end
                end
                c_st_final: begin
                    r_hash     <= w_sum;
                    r_hash_out <= w_digest;
                end
                default: ;
            endcase
        end
    end

endmodule : sha256_round_core
`default_nettype wire

// File: tb/tb_sha256_round_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_round_core
// Description : Self-checking bench for sha256_round_core. A W-generator
//               responder (latency 2) serves reads from a schedule computed
//               by a behavioural SHA-256 model; a scoreboard queue holds the
//               expected digest and latency of each block and a monitor
//               checks them whenever done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_round_core;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         first_block = 1'b0;
    logic         mode_224 = 1'b0;
    logic         w_reg_rdy = 1'b0;
    logic [31:0]  w_reg_data = '0;
    logic         w_reg_read;
    logic [5:0]   w_reg_addr;
    logic         busy;
    logic         done;
    logic [255:0] hash_out;

    always #5 clock = ~clock;

    sha256_round_core #(.W_LAT(2), .ROUNDS(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .first_block (first_block),
`ifdef SHA256_CORE_SHA224_EN
        .mode_224    (mode_224),
`endif
        .w_reg_rdy   (w_reg_rdy),
        .w_reg_data  (w_reg_data),
        .w_reg_read  (w_reg_read),
        .w_reg_addr  (w_reg_addr),
        .busy        (busy),
        .done        (done),
        .hash_out    (hash_out)
    );

    localparam logic [31:0] K_TBL [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                          32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] MSG_TWO_A = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] MSG_TWO_B = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    typedef struct {
        logic [255:0] hash;
        int           lat;
        int           t0;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [31:0] sched [64];
    logic [31:0] model_h [8];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          exp_addr = 64;
    logic        cap_read = 1'b0;
    logic [5:0]  cap_addr = '0;
    logic [31:0] w_pipe1 = '0;

    // ---------------- behavioural SHA-256 model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic load_block(input logic [511:0] m);
        for (int t = 0; t < 16; t++) sched[t] = m[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            sched[t] = (rotr(sched[t-2], 17) ^ rotr(sched[t-2], 19) ^ (sched[t-2] >> 10)) + sched[t-7] +
                       (rotr(sched[t-15], 7) ^ rotr(sched[t-15], 18) ^ (sched[t-15] >> 3)) + sched[t-16];
    endtask

    task automatic model_compress();
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        for (int i = 0; i < 8; i++) v[i] = model_h[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
                 ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TBL[t] + sched[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
                 ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) model_h[i] = model_h[i] + v[i];
    endtask

    // ---------------- W generator responder ----------------
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        w_pipe1    <= cap_read ? sched[cap_addr] : $urandom;
        w_reg_data <= w_pipe1;
    end

    always @(negedge clock) begin
        cap_read = w_reg_read;
        cap_addr = w_reg_addr;
        if (reset && w_reg_read) begin
            n_cmp++;
            if (int'(w_reg_addr) != exp_addr) begin
                n_bad++;
                $display("FAIL w_reg_addr: got %0d expected %0d", w_reg_addr, exp_addr);
            end
            exp_addr++;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (reset && done) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: done with no block outstanding, hash_out=%h", hash_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (hash_out !== mon_e.hash) begin
                    n_bad++;
                    $display("FAIL digest: got %h expected %h", hash_out, mon_e.hash);
                end
                if (mon_e.lat >= 0) begin
                    n_cmp++;
                    if (cyc - mon_e.t0 != mon_e.lat) begin
                        n_bad++;
                        $display("FAIL latency: got %0d expected %0d", cyc - mon_e.t0, mon_e.lat);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // mode 0: rdy always high; 1: rdy low cycles 20..24 plus a start pulse
    // while busy; 2: random rdy; 3: reset asserted at cycle arg.
    task automatic run_block(input logic [511:0] m, input logic fb, input logic m224,
                             input int lat, input int mode, input int arg);
        exp_t e;
        bit   got;
        load_block(m);
        if (fb) for (int i = 0; i < 8; i++) model_h[i] = m224 ? IV224[i] : IV256[i];
        model_compress();
        e.hash = {model_h[0], model_h[1], model_h[2], model_h[3],
                  model_h[4], model_h[5], model_h[6], model_h[7]};
        if (m224) e.hash[31:0] = '0;
        e.lat = lat;
        e.t0  = cyc;
        exp_q.push_back(e);
        exp_addr    = 0;
        first_block = fb;
        mode_224    = m224;
        w_reg_rdy   = 1'b1;
        start       = 1'b1;
        got = 0;
        for (int k = 1; k <= 400 && !got; k++) begin
            next_cycle();
            start = 1'b0;
            case (mode)
                1: begin
                    w_reg_rdy = !(k >= 20 && k < 25);
                    start     = (k == 30);
                end
                2: w_reg_rdy = ($urandom_range(0, 3) != 0);
                default: w_reg_rdy = 1'b1;
            endcase
            if (mode == 3 && k == arg) begin
                reset = 1'b0;
                exp_q.delete();
                @(negedge clock);
                check("reset_mid_block", {busy, done, w_reg_read, w_reg_addr, hash_out}, '0);
                next_cycle();
                next_cycle();
                reset    = 1'b1;
                exp_addr = 64;
                for (int i = 0; i < 8; i++) model_h[i] = '0;
                return;
            end
            if (done) got = 1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no done within 400 cycles, busy=%b", busy);
            exp_q.delete();
        end
    endtask

    task automatic idle(input int n);
        w_reg_rdy = 1'b1;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    initial begin
        logic [511:0] m;
        for (int i = 0; i < 8; i++) model_h[i] = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_state", {busy, done, w_reg_read, w_reg_addr, hash_out}, '0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // "abc", then a start pulse inside the DONE cycle must be ignored
        run_block(MSG_ABC, 1'b1, 1'b0, 69, 0, 0);
        check("abc_digest", hash_out, DIG_ABC);
        start       = 1'b1;
        first_block = 1'b1;
        next_cycle();
        start = 1'b0;
        check("start_in_done_ignored_busy", busy, 1'b0);
        idle(80);

        run_block(MSG_EMPTY, 1'b1, 1'b0, 69, 0, 0);
        check("empty_digest", hash_out, DIG_EMPTY);
        idle(2);

        run_block(MSG_TWO_A, 1'b1, 1'b0, 69, 0, 0);
        idle(1);
        run_block(MSG_TWO_B, 1'b0, 1'b0, 69, 0, 0);
        check("two_block_digest", hash_out, DIG_TWO);
        idle(3);

        // 5 stall cycles and a start pulse while busy
        run_block(MSG_ABC, 1'b1, 1'b0, 74, 1, 0);
        check("abc_stall_digest", hash_out, DIG_ABC);
        check("hash_out_holds", hash_out, DIG_ABC);
        idle(80);
        check("hash_out_held_idle", hash_out, DIG_ABC);

        // reset around round 30, then chain from the cleared H, then "abc"
        run_block(MSG_ABC, 1'b1, 1'b0, -1, 3, 35);
        idle(100);
        check("hash_out_after_reset", hash_out, '0);
        for (int i = 0; i < 16; i++) m[511 - 32*i -: 32] = $urandom;
        run_block(m, 1'b0, 1'b0, 69, 0, 0);
        idle(1);
        run_block(MSG_ABC, 1'b1, 1'b0, 69, 0, 0);
        check("abc_after_reset_digest", hash_out, DIG_ABC);
        idle(2);

        // random blocks, random chaining, random generator back-pressure
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 16; i++) m[511 - 32*i -: 32] = $urandom;
            run_block(m, (b == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, -1, 2, 0);
            idle($urandom_range(1, 4));
        end

`ifdef SHA256_CORE_SHA224_EN
        run_block(MSG_ABC, 1'b1, 1'b1, 69, 0, 0);
        check("sha224_abc_digest", hash_out,
              {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0});
        idle(2);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) m[511 - 32*i -: 32] = $urandom;
            run_block(m, 1'($urandom_range(0, 1)), 1'b1, -1, 2, 0);
            idle(2);
        end
`endif

        idle(10);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_sha256_round_core
`default_nettype wire
